// File: rtl/uart_tx_engine_pkg.sv
// uart_tx_engine_pkg: shared state encoding and helpers for the UART transmit engine
package uart_tx_engine_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
    function automatic logic parity_bit(input logic [31:0] data, input logic eps, input logic sp);
        return sp ? ~eps : (eps ? ^data : ~^data);
    endfunction
    function automatic int word_len(input logic [1:0] wls, input int min_w, input int max_w);
        return (min_w + int'(wls) > max_w) ? max_w : min_w + int'(wls);
    endfunction
endpackage

// File: rtl/uart_tx_engine_if.sv
// uart_tx_engine_if: THR head handshake between the holding register and the transmit engine
interface uart_tx_engine_if #(parameter int DW = 8);
    logic          thr_valid;
    logic [DW-1:0] thr_data;
    logic          thr_pop;
    modport master(output thr_valid, thr_data, input thr_pop);
    modport slave(input thr_valid, thr_data, output thr_pop);
endinterface

// File: rtl/uart_tx_engine_bit_timer.sv
// uart_tx_engine_bit_timer: counts oversample ticks and flags the last tick of each bit period
module uart_tx_engine_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic baud_tick,
    output logic bit_done
);
    localparam int TW = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    assign bit_done = ~clear & baud_tick & (tick_cnt_q == LAST);
    always_comb tick_cnt_d = (clear | bit_done) ? '0 : baud_tick ? tick_cnt_q + 1'b1 : tick_cnt_q;
    always_ff @(posedge pclk or negedge presetn)
        if (!presetn) tick_cnt_q <= '0;
        else tick_cnt_q <= tick_cnt_d;
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmit FSM with TSR shifter, latched frame config and registered txd
module uart_tx_engine
    import uart_tx_engine_pkg::*;
#(
    parameter int MAX_DATA_WIDTH = 8,
    parameter int MIN_DATA_WIDTH = 5,
    parameter int OVERSAMPLE     = 16
) (
    input  logic            pclk,
    input  logic            presetn,
    input  logic            utrst,
    input  logic            baud_tick,
    input  logic [1:0]      wls,
    input  logic            stb,
    input  logic            pen,
    input  logic            eps,
    input  logic            sp,
    input  logic            bc,
    uart_tx_engine_if.slave thr,
    output logic            txd,
    output logic            tx_busy,
    output logic            temt
);
    localparam int BW = $clog2(MAX_DATA_WIDTH + 1);
    tx_state_e                 state_q, state_d;
    logic [MAX_DATA_WIDTH-1:0] tsr_q, tsr_d, ld_data;
    logic [BW-1:0]             bit_cnt_q, bit_cnt_d, wlen_q, wlen_d, ld_wlen;
    logic                      stb_q, stb_d, pen_q, pen_d, par_q, par_d, stop2_q, stop2_d;
    logic                      txd_q, txd_d, bit_done, load;
    uart_tx_engine_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
        .pclk     (pclk),
        .presetn  (presetn),
        .clear    ((state_q == IDLE) | ~utrst),
        .baud_tick(baud_tick),
        .bit_done (bit_done)
    );
    assign ld_wlen = BW'(word_len(wls, MIN_DATA_WIDTH, MAX_DATA_WIDTH));
    assign ld_data = thr.thr_data & ~({MAX_DATA_WIDTH{1'b1}} << ld_wlen);
    always_comb begin
        state_d   = state_q;
        tsr_d     = tsr_q;
        bit_cnt_d = bit_cnt_q;
        wlen_d    = wlen_q;
        stb_d     = stb_q;
        pen_d     = pen_q;
        par_d     = par_q;
        stop2_d   = stop2_q;
        load      = 1'b0;
        case (state_q)
            IDLE:   load = thr.thr_valid;
            START:  if (bit_done) begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA:   if (bit_done) begin
                tsr_d     = tsr_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                stop2_d   = 1'b0;
                if (bit_cnt_q == wlen_q - 1'b1) state_d = pen_q ? PARITY : STOP;
            end
            PARITY: if (bit_done) begin
                state_d = STOP;
                stop2_d = 1'b0;
            end
            STOP:   if (bit_done) begin
                if (stb_q & ~stop2_q) stop2_d = 1'b1;
                else begin
                    state_d = IDLE;
                    load    = thr.thr_valid;
                end
            end
            default: state_d = IDLE;
        endcase
        // a pop from IDLE or from the last stop bit reloads straight into START
        if (load) begin
            state_d = START;
            tsr_d   = ld_data;
            wlen_d  = ld_wlen;
            stb_d   = stb;
            pen_d   = pen;
            par_d   = parity_bit(32'(ld_data), eps, sp);
        end
        if (!utrst) begin
            state_d   = IDLE;
            load      = 1'b0;
            tsr_d     = '0;
            bit_cnt_d = '0;
            stop2_d   = 1'b0;
        end
        txd_d = bc ? 1'b0 : state_d == START ? 1'b0 : state_d == DATA ? tsr_d[0] :
                state_d == PARITY ? par_q : 1'b1;
    end
    always_ff @(posedge pclk or negedge presetn)
        if (!presetn) begin
            state_q   <= IDLE;
            tsr_q     <= '0;
            bit_cnt_q <= '0;
            wlen_q    <= '0;
            stb_q     <= 1'b0;
            pen_q     <= 1'b0;
            par_q     <= 1'b0;
            stop2_q   <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            tsr_q     <= tsr_d;
            bit_cnt_q <= bit_cnt_d;
            wlen_q    <= wlen_d;
            stb_q     <= stb_d;
            pen_q     <= pen_d;
            par_q     <= par_d;
            stop2_q   <= stop2_d;
            txd_q     <= txd_d;
        end
    assign thr.thr_pop = load;
    assign txd         = txd_q;
    assign tx_busy     = state_q != IDLE;
    assign temt        = (state_q == IDLE) & ~thr.thr_valid;
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: table-driven frame checks plus queued, abort, break and reset sequences
module tb_uart_tx_engine;
    logic       pclk = 1'b0;
    logic       presetn, utrst, baud_tick, stb, pen, eps, sp, bc, txd, tx_busy, temt;
    logic [1:0] wls;
    int         total = 0, bad = 0, pops = 0, p0, k;
    typedef struct {
        logic [7:0]  data;
        logic [1:0]  wls;
        logic        stb, pen, eps, sp;
        int          nbits;
        logic [11:0] exp_bits;
        string       name;
    } vec_t;
    vec_t vecs[8];
    uart_tx_engine_if #(.DW(8)) thr_if();
    uart_tx_engine #(.MAX_DATA_WIDTH(8), .MIN_DATA_WIDTH(5), .OVERSAMPLE(16)) dut (
        .pclk(pclk), .presetn(presetn), .utrst(utrst), .baud_tick(baud_tick),
        .wls(wls), .stb(stb), .pen(pen), .eps(eps), .sp(sp), .bc(bc),
        .thr(thr_if), .txd(txd), .tx_busy(tx_busy), .temt(temt)
    );
    always #5 pclk = ~pclk;
    always @(posedge pclk) if (thr_if.thr_pop === 1'b1) pops <= pops + 1;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) begin
            @(negedge pclk);
            #1;
        end
    endtask
    task automatic wait_pop(input string nm);
        int w = 0;
        #1;
        while (thr_if.thr_pop !== 1'b1 && w < 64) begin
            step(1);
            w++;
        end
        chk({nm, " pop"}, 32'(thr_if.thr_pop), 1);
    endtask
    task automatic cfg(input logic [7:0] d, input logic [1:0] w, input logic s, input logic p,
                       input logic e, input logic t);
        thr_if.thr_data = d;
        wls = w; stb = s; pen = p; eps = e; sp = t;
        thr_if.thr_valid = 1'b1;
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        vecs[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 10, 12'h34A, "8N1_A5"};
        vecs[1] = '{8'h03, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 11, 12'h606, "7E2_03"};
        vecs[2] = '{8'h83, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 11, 12'h606, "7E2_83"};
        vecs[3] = '{8'h00, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 11, 12'h600, "stick_00"};
        vecs[4] = '{8'h01, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 11, 12'h402, "odd_01"};
        vecs[5] = '{8'hFF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0,  7, 12'h07E, "5N1_FF"};
        vecs[6] = '{8'h2A, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0,  9, 12'h154, "6O1_2A"};
        vecs[7] = '{8'h07, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 12, 12'hE0E, "8E2_07"};
        presetn = 1'b0; utrst = 1'b1; baud_tick = 1'b1; bc = 1'b0;
        wls = 2'd3; stb = 1'b0; pen = 1'b0; eps = 1'b0; sp = 1'b0;
        thr_if.thr_valid = 1'b0; thr_if.thr_data = 8'h00;
        step(3);
        chk("rst txd", 32'(txd), 1);
        chk("rst pop", 32'(thr_if.thr_pop), 0);
        chk("rst busy", 32'(tx_busy), 0);
        chk("rst temt", 32'(temt), 1);
        presetn = 1'b1;
        step(2);
        for (int v = 0; v < 8; v++) begin
            cfg(vecs[v].data, vecs[v].wls, vecs[v].stb, vecs[v].pen, vecs[v].eps, vecs[v].sp);
            p0 = pops;
            wait_pop(vecs[v].name);
            step(1);
            thr_if.thr_valid = 1'b0;
            step(7);
            for (int b = 0; b < vecs[v].nbits; b++) begin
                chk($sformatf("%s bit%0d", vecs[v].name, b), 32'(txd), 32'(vecs[v].exp_bits[b]));
                if (b < vecs[v].nbits - 1) step(16);
            end
            step(8);
            chk({vecs[v].name, " busy end"}, 32'(tx_busy), 1);
            step(1);
            chk({vecs[v].name, " idle"}, 32'(tx_busy), 0);
            chk({vecs[v].name, " temt"}, 32'(temt), 1);
            chk({vecs[v].name, " txd idle"}, 32'(txd), 1);
            chk({vecs[v].name, " pops"}, 32'(pops - p0), 1);
            step(2);
        end
        // back-to-back words: second pop on the last stop tick, start bit right after
        cfg(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        p0 = pops;
        wait_pop("queue first");
        k = 0;
        do begin
            step(1);
            k++;
        end while (thr_if.thr_pop !== 1'b1 && k < 400);
        chk("queue gap", 32'(k), 160);
        step(1);
        thr_if.thr_valid = 1'b0;
        chk("queue start txd", 32'(txd), 0);
        chk("queue busy", 32'(tx_busy), 1);
        step(160);
        chk("queue idle", 32'(tx_busy), 0);
        chk("queue pops", 32'(pops - p0), 2);
        step(2);
        // utrst dropped during data bit 3
        cfg(8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        p0 = pops;
        wait_pop("abort");
        step(1);
        thr_if.thr_valid = 1'b0;
        step(71);
        chk("abort pre txd", 32'(txd), 0);
        utrst = 1'b0;
        step(1);
        chk("abort txd", 32'(txd), 1);
        chk("abort busy", 32'(tx_busy), 0);
        thr_if.thr_valid = 1'b1;
        #1;
        chk("abort no pop", 32'(thr_if.thr_pop), 0);
        step(3);
        chk("abort pops", 32'(pops - p0), 1);
        chk("abort still idle", 32'(tx_busy), 0);
        thr_if.thr_valid = 1'b0;
        utrst = 1'b1;
        step(40);
        chk("abort resume idle", 32'(tx_busy), 0);
        chk("abort temt", 32'(temt), 1);
        // break mid-frame plus config changes that must not affect the frame
        cfg(8'hFF, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_pop("break");
        step(1);
        thr_if.thr_valid = 1'b0;
        step(39);
        chk("break pre txd", 32'(txd), 1);
        bc = 1'b1; pen = 1'b1; stb = 1'b1;
        step(1);
        chk("break txd", 32'(txd), 0);
        step(15);
        chk("break held", 32'(txd), 0);
        bc = 1'b0;
        step(1);
        chk("break release", 32'(txd), 1);
        step(103);
        chk("break busy end", 32'(tx_busy), 1);
        step(1);
        chk("break idle", 32'(tx_busy), 0);
        pen = 1'b0; stb = 1'b0;
        step(2);
        // reset in the middle of a frame
        cfg(8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_pop("reset");
        step(1);
        thr_if.thr_valid = 1'b0;
        step(40);
        presetn = 1'b0;
        #1;
        chk("midrst txd", 32'(txd), 1);
        chk("midrst temt", 32'(temt), 1);
        chk("midrst pop", 32'(thr_if.thr_pop), 0);
        step(2);
        presetn = 1'b1;
        step(40);
        chk("midrst idle", 32'(tx_busy), 0);
        chk("midrst txd idle", 32'(txd), 1);
        cfg(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_pop("midrst resume");
        step(1);
        thr_if.thr_valid = 1'b0;
        chk("midrst resume start", 32'(txd), 0);
        step(170);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
